// File: rtl/sc_mac_seq.sv
// sc_mac_seq: sequencer for a stochastic-computing multiply-accumulate.
// For each of TERMS product terms it loads an operand pair, clears the
// toggle/product datapath, sweeps the shared SNG counter over L = 2^LEN_W
// values and counts the ones coming back on prod_bit into acc.
module sc_mac_seq #(
  parameter int LEN_W = 4,
  parameter int TERMS = 2,
  parameter int ACC_W = LEN_W + $clog2(TERMS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [LEN_W-1:0] op_a,
  input  logic [LEN_W-1:0] op_b,
  output logic [LEN_W-1:0] a_q,
  output logic [LEN_W-1:0] b_q,
  output logic [LEN_W-1:0] sng_cnt,
  output logic             sng_en,
  output logic             tq_clr,
  input  logic             prod_bit,
  output logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic             done
);

  localparam int TI_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [LEN_W-1:0] CNT_MAX   = {LEN_W{1'b1}};
  localparam logic [TI_W-1:0]  TERM_LAST = TI_W'(TERMS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLR   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] opa_q;
  logic [LEN_W-1:0] opb_q;
  logic [LEN_W-1:0] cnt_q;
  logic [TI_W-1:0]  term_q;
  logic [ACC_W-1:0] acc_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;
  logic             en_q;
  logic             clr_q;
  // High in the cycle after a RUN cycle: prod_bit then carries that cycle's product.
  logic             samp_q;

  // ACC_W is sized for TERMS*L, so the clamp never engages in a legal
  // configuration; it only guarantees the count can never wrap.
  function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
    return (&v) ? v : v + ACC_W'(1);
  endfunction

  // Sequencer FSM with registered control outputs and the ones-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      samp_q  <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      samp_q <= (state_q == RUN);
      if (samp_q && prod_bit) begin
        acc_q <= sat_inc(acc_q);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            term_q  <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (op_valid) begin
            opa_q   <= op_a;
            opb_q   <= op_b;
            ready_q <= 1'b0;
            clr_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= CLR;
          end
        end
        CLR: begin
          en_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // The counter wraps back to 0 after the last value of the sweep.
          cnt_q <= cnt_q + LEN_W'(1);
          if (cnt_q == CNT_MAX) begin
            en_q    <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // The final product sample of the term lands on this edge.
          if (term_q == TERM_LAST) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            term_q  <= term_q + TI_W'(1);
            ready_q <= 1'b1;
            state_q <= LOAD;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign op_ready = ready_q;
  assign a_q      = opa_q;
  assign b_q      = opb_q;
  assign sng_cnt  = cnt_q;
  assign sng_en   = en_q;
  assign tq_clr   = clr_q;
  assign acc      = acc_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sc_mac_seq.sv
// Directed bench for sc_mac_seq (LEN_W=4, TERMS=2).
module tb_sc_mac_seq;

  localparam int LEN_W = 4;
  localparam int TERMS = 2;
  localparam int ACC_W = LEN_W + $clog2(TERMS) + 1;
  localparam int L     = 1 << LEN_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             op_valid;
  logic             op_ready;
  logic [LEN_W-1:0] op_a;
  logic [LEN_W-1:0] op_b;
  logic [LEN_W-1:0] a_q;
  logic [LEN_W-1:0] b_q;
  logic [LEN_W-1:0] sng_cnt;
  logic             sng_en;
  logic             tq_clr;
  logic             prod_bit;
  logic [ACC_W-1:0] acc;
  logic             busy;
  logic             done;

  int n_chk  = 0;
  int n_fail = 0;

  sc_mac_seq #(.LEN_W(LEN_W), .TERMS(TERMS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .a_q      (a_q),
    .b_q      (b_q),
    .sng_cnt  (sng_cnt),
    .sng_en   (sng_en),
    .tq_clr   (tq_clr),
    .prod_bit (prod_bit),
    .acc      (acc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // mode: 0 prod tied 1, 1 tied 0, 2 alternating, 3 prod = (cnt < a_q)
  typedef struct {
    int         mode;
    logic [3:0] a;
    logic [3:0] b;
    int         gap;
    bit         poke;
    int         exp_acc;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_acc"},      int'(acc), 0);
    chk({tag, "_a_q"},      int'(a_q), 0);
    chk({tag, "_b_q"},      int'(b_q), 0);
    chk({tag, "_sng_cnt"},  int'(sng_cnt), 0);
    chk({tag, "_ctrl"},     int'({busy, done, op_ready, sng_en, tq_clr}), 0);
  endtask

  // Runs one MAC operation from a start pulse to done, checking as it goes.
  task automatic run_op(input vec_t v, input int idx);
    int cyc, lat, term_no, wait_n, exp_cnt;
    int n_clr, n_en, n_rdy, cnt_err, op_err, overlap;
    logic pend;
    logic [ACC_W-1:0] acc_done;
    string tag;
    tag = $sformatf("v%0d", idx);
    term_no = 0; wait_n = 0; exp_cnt = 0; lat = -1;
    n_clr = 0; n_en = 0; n_rdy = 0; cnt_err = 0; op_err = 0; overlap = 0;
    pend = 1'b0;
    prod_bit = 1'b0;
    op_valid = 1'b1;
    @(negedge clk);
    start = 1'b1;
    op_a = v.a;
    op_b = v.b;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      // observe
      if (tq_clr) begin
        n_clr++;
        term_no = n_clr;
        exp_cnt = 0;
        if (sng_cnt != '0) cnt_err++;
      end
      if (sng_en) begin
        n_en++;
        if (int'(sng_cnt) != exp_cnt) cnt_err++;
        exp_cnt++;
        if (a_q != v.a || b_q != v.b) op_err++;
      end
      if (op_ready) n_rdy++;
      if (op_ready && sng_en) overlap++;
      if (done) begin
        lat = cyc;
        break;
      end
      // drive for the next edge
      case (v.mode)
        0: prod_bit = 1'b1;
        1: prod_bit = 1'b0;
        2: prod_bit = ~prod_bit;
        default: begin
          prod_bit = pend;
          pend = sng_en && (sng_cnt < a_q);
        end
      endcase
      if (op_ready && term_no == 1 && wait_n < v.gap) begin
        op_valid = 1'b0;
        wait_n++;
      end else begin
        op_valid = 1'b1;
      end
      op_a = op_ready ? v.a : ~v.a;
      op_b = op_ready ? v.b : ~v.b;
      start = v.poke && sng_en && term_no == 1 && sng_cnt == 4'd3;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_acc"}, int'(acc), v.exp_acc);
    chk({tag, "_busy_at_done"}, int'(busy), 1);
    chk({tag, "_tq_clr_pulses"}, n_clr, TERMS);
    chk({tag, "_sng_en_cycles"}, n_en, TERMS * L);
    chk({tag, "_sng_cnt_seq_err"}, cnt_err, 0);
    chk({tag, "_operand_stable_err"}, op_err, 0);
    chk({tag, "_ready_en_overlap"}, overlap, 0);
    chk({tag, "_ready_cycles"}, n_rdy, TERMS + v.gap);
    acc_done = acc;
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, int'(done), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_acc_hold"}, int'(acc), int'(acc_done));
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; prod_bit = 1'b0;

    //            mode a      b      gap poke acc lat
    vecs[0] = '{0, 4'd9,  4'd3,  0, 1'b0, 32, 39};
    vecs[1] = '{1, 4'd6,  4'd10, 0, 1'b0, 0,  39};
    vecs[2] = '{2, 4'd1,  4'd14, 0, 1'b0, 16, 39};
    vecs[3] = '{0, 4'd7,  4'd2,  5, 1'b0, 32, 44};
    vecs[4] = '{0, 4'd4,  4'd11, 0, 1'b1, 32, 39};
    vecs[5] = '{3, 4'd5,  4'd8,  0, 1'b0, 10, 39};
    vecs[6] = '{3, 4'd12, 4'd15, 2, 1'b1, 24, 41};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], i);
    end

    // Reset in the middle of term 0's sweep, then a clean operation.
    @(negedge clk);
    start = 1'b1; op_valid = 1'b1; op_a = 4'd3; op_b = 4'd5; prod_bit = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!(sng_en && sng_cnt == 4'd7) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("rst_reach_cnt7", int'(guard < 100), 1);
    chk("rst_acc_before", int'(acc != '0), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("midrun_rst");
    rst = 1'b0;
    prod_bit = 1'b0;
    run_op(vecs[0], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop if something leaves the bench stuck.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
